// File: rtl/lsu_if.sv
// Bundles the three LSU-facing ports: request from the ALU stage,
// the word-wide data-memory port, and the writeback result.
// The LSU uses the slave side; whoever surrounds it uses the master side.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic [1:0]  wb_cause;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready,
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output wb_valid, wb_rd, wb_data, wb_err, wb_cause
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready,
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  wb_valid, wb_rd, wb_data, wb_err, wb_cause
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one word-wide memory transaction per RV32I load/store,
// with lane placement for stores, sign/zero extension for loads, and
// error reporting for misalignment, illegal widths and memory timeouts.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic   clk,
    input logic   rst,
    lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t      state_q;
    logic        opWe_q;
    logic [2:0]  opFunct3_q;
    logic [1:0]  opAddrLow_q;
    logic [4:0]  opRd_q;
    logic [31:0] timeoutCnt_q;
    logic [31:0] timeoutCnt_d;

    logic        reqIllegal;
    logic        reqMisaligned;
    logic [31:0] storeWdata;
    logic [3:0]  storeWstrb;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;
    logic        timeoutHit;

    assign bus.req_ready = (state_q == IDLE) && !rst;

    // Classify the incoming request: illegal width codes first, then alignment.
    always_comb begin
        reqIllegal = 1'b1;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: reqIllegal = 1'b0;
            3'b100, 3'b101:         reqIllegal = bus.req_we;
            default:                reqIllegal = 1'b1;
        endcase
        reqMisaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end

    // Replicate store data across lanes and pick byte enables from the low address bits.
    always_comb begin
        storeWdata = bus.req_wdata;
        storeWstrb = 4'b1111;
        case (bus.req_funct3[1:0])
            2'b00: begin
                storeWdata = {4{bus.req_wdata[7:0]}};
                storeWstrb = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                storeWdata = {2{bus.req_wdata[15:0]}};
                storeWstrb = 4'b0011 << bus.req_addr[1:0];
            end
            default: begin
                storeWdata = bus.req_wdata;
                storeWstrb = 4'b1111;
            end
        endcase
    end

    // Pull the addressed byte/half out of the returned word and extend it.
    always_comb begin
        case (opAddrLow_q)
            2'b00:   loadByte = bus.mem_rdata[7:0];
            2'b01:   loadByte = bus.mem_rdata[15:8];
            2'b10:   loadByte = bus.mem_rdata[23:16];
            default: loadByte = bus.mem_rdata[31:24];
        endcase
        loadHalf = opAddrLow_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (opFunct3_q)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b100:  loadData = {24'd0, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  loadData = {16'd0, loadHalf};
            default: loadData = bus.mem_rdata;
        endcase
    end

    // Timeout counter saturates at its limit so a late handshake can still win once.
    always_comb begin
        timeoutHit   = (TIMEOUT_CYCLES != 0) && (timeoutCnt_q == TIMEOUT_CYCLES);
        timeoutCnt_d = timeoutHit ? timeoutCnt_q : timeoutCnt_q + 32'd1;
    end

    // Transaction FSM with all memory and writeback outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            opWe_q        <= 1'b0;
            opFunct3_q    <= 3'd0;
            opAddrLow_q   <= 2'd0;
            opRd_q        <= 5'd0;
            timeoutCnt_q  <= 32'd0;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wstrb <= 4'd0;
            bus.mem_wdata <= 32'd0;
            bus.wb_valid  <= 1'b0;
            bus.wb_rd     <= 5'd0;
            bus.wb_data   <= 32'd0;
            bus.wb_err    <= 1'b0;
            bus.wb_cause  <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        opWe_q       <= bus.req_we;
                        opFunct3_q   <= bus.req_funct3;
                        opAddrLow_q  <= bus.req_addr[1:0];
                        opRd_q       <= bus.req_rd;
                        timeoutCnt_q <= 32'd0;
                        if (reqIllegal || reqMisaligned) begin
                            state_q      <= DONE;
                            bus.wb_valid <= 1'b1;
                            bus.wb_rd    <= 5'd0;
                            bus.wb_data  <= 32'd0;
                            bus.wb_err   <= 1'b1;
                            bus.wb_cause <= reqIllegal ? 2'b10 : 2'b01;
                        end else begin
                            state_q       <= REQ;
                            bus.mem_valid <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_wstrb <= bus.req_we ? storeWstrb : 4'd0;
                            bus.mem_wdata <= bus.req_we ? storeWdata : 32'd0;
                        end
                    end
                end
                REQ: begin
                    timeoutCnt_q <= timeoutCnt_d;
                    if (bus.mem_ready) begin
                        state_q       <= WAIT;
                        bus.mem_valid <= 1'b0;
                    end else if (timeoutHit) begin
                        state_q       <= DONE;
                        bus.mem_valid <= 1'b0;
                        bus.wb_valid  <= 1'b1;
                        bus.wb_rd     <= 5'd0;
                        bus.wb_data   <= 32'd0;
                        bus.wb_err    <= 1'b1;
                        bus.wb_cause  <= 2'b11;
                    end
                end
                WAIT: begin
                    timeoutCnt_q <= timeoutCnt_d;
                    if (bus.mem_rvalid) begin
                        state_q      <= DONE;
                        bus.wb_valid <= 1'b1;
                        bus.wb_rd    <= opWe_q ? 5'd0 : opRd_q;
                        bus.wb_data  <= opWe_q ? 32'd0 : loadData;
                        bus.wb_err   <= 1'b0;
                        bus.wb_cause <= 2'b00;
                    end else if (timeoutHit) begin
                        state_q      <= DONE;
                        bus.wb_valid <= 1'b1;
                        bus.wb_rd    <= 5'd0;
                        bus.wb_data  <= 32'd0;
                        bus.wb_err   <= 1'b1;
                        bus.wb_cause <= 2'b11;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    bus.wb_valid <= 1'b0;
                    bus.wb_rd    <= 5'd0;
                    bus.wb_data  <= 32'd0;
                    bus.wb_err   <= 1'b0;
                    bus.wb_cause <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit: a vector table of single
// transactions with the fastest memory handshake, plus hand-written
// sequences for timeout, late handshake and reset in mid-transaction.
module tb_lsu;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    lsu_if bus ();

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] expMemAddr;
        logic [3:0]  expWstrb;
        logic [31:0] expWdata;
        logic [1:0]  expCause;
        logic [31:0] expWbData;
        logic [4:0]  expWbRd;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t makeVec(input string name, input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [4:0] rd, input logic [31:0] rdata,
                                     input logic [31:0] expMemAddr, input logic [3:0] expWstrb,
                                     input logic [31:0] expWdata, input logic [1:0] expCause,
                                     input logic [31:0] expWbData, input logic [4:0] expWbRd);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rd = rd; v.rdata = rdata; v.expMemAddr = expMemAddr; v.expWstrb = expWstrb;
        v.expWdata = expWdata; v.expCause = expCause; v.expWbData = expWbData;
        v.expWbRd = expWbRd;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "/mem_valid"}, {31'd0, bus.mem_valid}, 32'd0);
        checkOutput({tag, "/mem_we"},    {31'd0, bus.mem_we},    32'd0);
        checkOutput({tag, "/mem_addr"},  bus.mem_addr,           32'd0);
        checkOutput({tag, "/mem_wstrb"}, {28'd0, bus.mem_wstrb}, 32'd0);
        checkOutput({tag, "/mem_wdata"}, bus.mem_wdata,          32'd0);
        checkOutput({tag, "/wb_valid"},  {31'd0, bus.wb_valid},  32'd0);
        checkOutput({tag, "/wb_rd"},     {27'd0, bus.wb_rd},     32'd0);
        checkOutput({tag, "/wb_data"},   bus.wb_data,            32'd0);
        checkOutput({tag, "/wb_err"},    {31'd0, bus.wb_err},    32'd0);
        checkOutput({tag, "/wb_cause"},  {30'd0, bus.wb_cause},  32'd0);
    endtask

    // One transaction from the table, using the fastest memory handshake.
    task automatic applyStimulus(input vec_t v);
        checkOutput({v.name, "/req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        driveReq(v.we, v.f3, v.addr, v.wdata, v.rd);
        if (v.expCause != 2'd0) begin
            checkOutput({v.name, "/mem_valid"}, {31'd0, bus.mem_valid}, 32'd0);
            checkOutput({v.name, "/wb_valid"},  {31'd0, bus.wb_valid},  32'd1);
            checkOutput({v.name, "/wb_err"},    {31'd0, bus.wb_err},    32'd1);
            checkOutput({v.name, "/wb_cause"},  {30'd0, bus.wb_cause},  {30'd0, v.expCause});
            checkOutput({v.name, "/wb_rd"},     {27'd0, bus.wb_rd},     32'd0);
            checkOutput({v.name, "/wb_data"},   bus.wb_data,            32'd0);
            tick();
            checkOutput({v.name, "/wb_valid_drop"}, {31'd0, bus.wb_valid}, 32'd0);
            checkOutput({v.name, "/mem_valid_after"}, {31'd0, bus.mem_valid}, 32'd0);
        end else begin
            checkOutput({v.name, "/mem_valid"}, {31'd0, bus.mem_valid}, 32'd1);
            checkOutput({v.name, "/mem_we"},    {31'd0, bus.mem_we},    {31'd0, v.we});
            checkOutput({v.name, "/mem_addr"},  bus.mem_addr,           v.expMemAddr);
            checkOutput({v.name, "/mem_wstrb"}, {28'd0, bus.mem_wstrb}, {28'd0, v.expWstrb});
            checkOutput({v.name, "/mem_wdata"}, bus.mem_wdata,          v.expWdata);
            checkOutput({v.name, "/req_ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
            bus.mem_ready = 1'b1;
            tick();
            bus.mem_ready = 1'b0;
            checkOutput({v.name, "/mem_valid_wait"}, {31'd0, bus.mem_valid}, 32'd0);
            checkOutput({v.name, "/wb_valid_wait"},  {31'd0, bus.wb_valid},  32'd0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = v.rdata;
            tick();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'd0;
            checkOutput({v.name, "/wb_valid"}, {31'd0, bus.wb_valid}, 32'd1);
            checkOutput({v.name, "/wb_err"},   {31'd0, bus.wb_err},   32'd0);
            checkOutput({v.name, "/wb_cause"}, {30'd0, bus.wb_cause}, 32'd0);
            checkOutput({v.name, "/wb_data"},  bus.wb_data,           v.expWbData);
            checkOutput({v.name, "/wb_rd"},    {27'd0, bus.wb_rd},    {27'd0, v.expWbRd});
            tick();
            checkOutput({v.name, "/wb_valid_drop"}, {31'd0, bus.wb_valid}, 32'd0);
        end
        checkOutput({v.name, "/req_ready_next"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = makeVec("LB",       1'b0, 3'b000, 32'h0000_1003, 32'h0,         5'd5,  32'h80FF_1234,
                           32'h0000_1000, 4'b0000, 32'h0,         2'd0, 32'hFFFF_FF80, 5'd5);
        vecs[1]  = makeVec("LHU",      1'b0, 3'b101, 32'h0000_2002, 32'h0,         5'd6,  32'hBEEF_0000,
                           32'h0000_2000, 4'b0000, 32'h0,         2'd0, 32'h0000_BEEF, 5'd6);
        vecs[2]  = makeVec("SH",       1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 5'd7,  32'hFFFF_FFFF,
                           32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 2'd0, 32'h0,         5'd0);
        vecs[3]  = makeVec("LW_mis",   1'b0, 3'b010, 32'h0000_4001, 32'h0,         5'd8,  32'h0,
                           32'h0,         4'b0000, 32'h0,         2'd1, 32'h0,         5'd0);
        vecs[4]  = makeVec("SW_f3_100",1'b1, 3'b100, 32'h0000_4000, 32'h1111_2222, 5'd8,  32'h0,
                           32'h0,         4'b0000, 32'h0,         2'd2, 32'h0,         5'd0);
        vecs[5]  = makeVec("LW",       1'b0, 3'b010, 32'h0000_5000, 32'h0,         5'd31, 32'hDEAD_BEEF,
                           32'h0000_5000, 4'b0000, 32'h0,         2'd0, 32'hDEAD_BEEF, 5'd31);
        vecs[6]  = makeVec("SB",       1'b1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 5'd2,  32'hFFFF_FFFF,
                           32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 2'd0, 32'h0,         5'd0);
        vecs[7]  = makeVec("LH",       1'b0, 3'b001, 32'h0000_7000, 32'h0,         5'd10, 32'h1234_8001,
                           32'h0000_7000, 4'b0000, 32'h0,         2'd0, 32'hFFFF_8001, 5'd10);
        vecs[8]  = makeVec("LBU",      1'b0, 3'b100, 32'h0000_8002, 32'h0,         5'd11, 32'h00C3_0000,
                           32'h0000_8000, 4'b0000, 32'h0,         2'd0, 32'h0000_00C3, 5'd11);
        vecs[9]  = makeVec("SW",       1'b1, 3'b010, 32'h0000_9000, 32'hCAFE_F00D, 5'd12, 32'hFFFF_FFFF,
                           32'h0000_9000, 4'b1111, 32'hCAFE_F00D, 2'd0, 32'h0,         5'd0);
        vecs[10] = makeVec("LH_mis",   1'b0, 3'b001, 32'h0000_7003, 32'h0,         5'd13, 32'h0,
                           32'h0,         4'b0000, 32'h0,         2'd1, 32'h0,         5'd0);
        vecs[11] = makeVec("L_f3_011", 1'b0, 3'b011, 32'h0000_7000, 32'h0,         5'd14, 32'h0,
                           32'h0,         4'b0000, 32'h0,         2'd2, 32'h0,         5'd0);
        vecs[12] = makeVec("S_f3_101", 1'b1, 3'b101, 32'h0000_7001, 32'h0,         5'd15, 32'h0,
                           32'h0,         4'b0000, 32'h0,         2'd2, 32'h0,         5'd0);
        vecs[13] = makeVec("LHU_mis",  1'b0, 3'b101, 32'h0000_2001, 32'h0,         5'd16, 32'h0,
                           32'h0,         4'b0000, 32'h0,         2'd1, 32'h0,         5'd0);
        vecs[14] = makeVec("SB_lane3", 1'b1, 3'b000, 32'h0000_6003, 32'hFFFF_FF3C, 5'd1,  32'hFFFF_FFFF,
                           32'h0000_6000, 4'b1000, 32'h3C3C_3C3C, 2'd0, 32'h0,         5'd0);

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_rd     = 5'd0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        tick();
        tick();
        checkOutput("reset/req_ready", {31'd0, bus.req_ready}, 32'd0);
        checkAllZero("reset");
        rst = 1'b0;
        #1;
        checkOutput("reset/req_ready_release", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
        end

        // Timeout: memory never accepts, abort lands at N+T+2 with T=4.
        driveReq(1'b0, 3'b010, 32'h0000_B000, 32'd0, 5'd3);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("timeout/mem_valid_held", {31'd0, bus.mem_valid}, 32'd1);
            checkOutput("timeout/wb_valid_early", {31'd0, bus.wb_valid},  32'd0);
            tick();
        end
        checkOutput("timeout/mem_valid_last", {31'd0, bus.mem_valid}, 32'd1);
        checkOutput("timeout/wb_valid_last",  {31'd0, bus.wb_valid},  32'd0);
        tick();
        checkOutput("timeout/wb_valid", {31'd0, bus.wb_valid},  32'd1);
        checkOutput("timeout/wb_err",   {31'd0, bus.wb_err},    32'd1);
        checkOutput("timeout/wb_cause", {30'd0, bus.wb_cause},  32'd3);
        checkOutput("timeout/mem_valid",{31'd0, bus.mem_valid}, 32'd0);
        checkOutput("timeout/wb_rd",    {27'd0, bus.wb_rd},     32'd0);
        tick();
        checkOutput("timeout/wb_valid_drop", {31'd0, bus.wb_valid}, 32'd0);

        // Handshake arrives in the timeout cycle itself: the response wins.
        driveReq(1'b0, 3'b010, 32'h0000_A000, 32'd0, 5'd4);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("late/wb_valid_early", {31'd0, bus.wb_valid}, 32'd0);
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        checkOutput("late/mem_valid_wait", {31'd0, bus.mem_valid}, 32'd0);
        checkOutput("late/wb_valid_wait",  {31'd0, bus.wb_valid},  32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1122_3344;
        tick();
        bus.mem_rvalid = 1'b0;
        checkOutput("late/wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        checkOutput("late/wb_err",   {31'd0, bus.wb_err},   32'd0);
        checkOutput("late/wb_cause", {30'd0, bus.wb_cause}, 32'd0);
        checkOutput("late/wb_data",  bus.wb_data,           32'h1122_3344);
        checkOutput("late/wb_rd",    {27'd0, bus.wb_rd},    32'd4);
        tick();

        // Reset while waiting for the response; the stray response is ignored.
        driveReq(1'b0, 3'b010, 32'h0000_C004, 32'd0, 5'd9);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        checkOutput("rstwait/mem_addr_live", bus.mem_addr, 32'h0000_C004);
        rst = 1'b1;
        #1;
        checkOutput("rstwait/req_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rstwait/req_ready_after", {31'd0, bus.req_ready}, 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5566_7788;
        tick();
        bus.mem_rvalid = 1'b0;
        checkAllZero("rstwait");
        tick();
        checkOutput("rstwait/wb_valid_later", {31'd0, bus.wb_valid}, 32'd0);
        checkOutput("rstwait/req_ready_idle", {31'd0, bus.req_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the RISC-V core. It takes the ALU-computed effective address plus store data for one memory instruction, performs a single word-wide transaction on the data-memory port, and returns the aligned, sign- or zero-extended load result (or a store acknowledge) to writeback. Misaligned accesses, illegal funct3 values and memory timeouts are reported as errors. No request is ever issued to memory for an access that errors before the bus phase.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in REQ+WAIT before aborting. A value of 0 disables the timeout.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: the ALU stage presents a memory operation.
- `req_ready` out 1: the LSU accepts a request this cycle; equals (state==IDLE) & ~rst.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code.
  - 000 = B, 001 = H, 010 = W.
  - 100 = BU, 101 = HU (loads only).
- `req_addr` in 32: effective address (ALU result).
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: destination register.
- `mem_valid` out 1: memory request valid.
- `mem_ready` in 1: memory accepts the request.
- `mem_we` out 1: store request.
- `mem_addr` out 32: word address, {addr[31:2], 2'b00}.
- `mem_wstrb` out 4: byte enables; 0 for loads.
- `mem_wdata` out 32: lane-replicated store data; 0 for loads.
- `mem_rvalid` in 1: response/acknowledge; asserted for both loads and stores.
- `mem_rdata` in 32: load word.
- `wb_valid` out 1: one-cycle completion pulse.
- `wb_rd` out 5: destination register; forced to 0 for stores and errors.
- `wb_data` out 32: extended load data; 0 for stores and errors.
- `wb_err` out 1: access failed.
- `wb_cause` out 2: error cause.
  - 00 none, 01 misaligned, 10 illegal funct3, 11 timeout.

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **IDLE:** `req_ready`=1. When `req_valid` is high, latch we/funct3/addr/wdata/rd and clear the timeout counter.
  - Illegal funct3 → DONE with cause 10. For stores, only 000/001/010 are legal; for loads, 000/001/010/100/101 are legal.
  - Otherwise, misaligned (H with addr[0]=1, or W with addr[1:0]≠0) → DONE with cause 01.
  - Otherwise → REQ.
- **REQ:** `mem_valid`=1; address, strobes and data are held stable until `mem_ready`. On `mem_ready` → WAIT.
- **WAIT:** `mem_valid`=0. On `mem_rvalid` → DONE; capture `mem_rdata` for loads. `mem_rvalid` is sampled only in WAIT.
- **Timeout:** the counter increments every cycle in REQ or WAIT. When it equals TIMEOUT_CYCLES (nonzero), go → DONE with cause 11. If `mem_ready` or `mem_rvalid` arrives in the same cycle, the response wins and no error is raised.
- **DONE:** `wb_valid`=1 for exactly one cycle, then → IDLE. There is no backpressure from writeback.
- **Store lanes:**
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 4'b0011 << addr[1:0].
  - SW: wdata = rs2, wstrb = 4'b1111.
- **Load extract:**
  - B/BU: byte = rdata >> (8*addr[1:0]).
  - H/HU: half = rdata >> (16*addr[1]).
  - B and H sign-extend from bit 7 or bit 15; BU and HU zero-extend; W passes through.
- **Reset:** `rst` in any state (including mid-transaction) returns to IDLE next edge and aborts the in-flight access; a later stray `mem_rvalid` is ignored.
  - Registered outputs reset to 0: mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, wb_valid, wb_rd, wb_data, wb_err, wb_cause.
  - `req_ready`=0 while `rst` is high.

## Timing
- Request accepted on edge N (IDLE, `req_valid`=1).
- `mem_valid` is high from cycle N+1.
- Fastest completion: `mem_ready`=1 in cycle N+1 and `mem_rvalid`=1 in cycle N+2, giving `wb_valid` in cycle N+3.
- The next request can be accepted in cycle N+4.
- Pre-bus errors: `wb_valid` in cycle N+1, with `mem_valid` never asserted.
- Timeout with TIMEOUT_CYCLES=T: `wb_valid` in cycle N+T+2.
- All outputs are registered except `req_ready`.

## Test plan
- **LB:** addr 0x1003 with mem_rdata 0x80FF_1234 → mem_addr 0x1000, mem_wstrb 0; wb_data 0xFFFF_FF80, wb_valid pulses once, 3 cycles after accept.
- **LHU:** addr 0x2002 with rdata 0xBEEF_0000 → wb_data 0x0000_BEEF.
- **SH:** addr 0x3002 with rs2 0x1234_ABCD, rd=7 → mem_wdata 0xABCD_ABCD, mem_wstrb 4'b1100, mem_we 1; wb_rd 0, wb_err 0.
- **Pre-bus errors:** LW at 0x4001 → mem_valid stays 0; wb_err 1, cause 01, 1 cycle after accept. SW with funct3 100 → cause 10.
- **Timeout:** TIMEOUT_CYCLES=4, mem_ready held 0 → wb_valid with cause 11 in cycle N+6, mem_valid deasserted. A second run with mem_ready in the timeout cycle → no error.
- **Reset mid-WAIT:** rst for 1 cycle, then mem_rvalid → no wb_valid; req_ready=1 the cycle after rst falls; all outputs 0.
